// File: rtl/seq_mul_div_unit.sv
// Unsigned sequential shift-add multiplier / restoring divider.
// One iteration per clock, start/busy/done handshake, held results.
module seq_mul_div_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_st,
    input  logic             div_st,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL_STEP,
        DIV_STEP,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             err_q;

    logic             accept;
    logic             illegal;
    logic             div_zero;
    logic             last;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   hi_nx;
    logic [WIDTH-1:0] lo_nx;

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign div_zero = accept & ~mul_st & (op_b == '0);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        illegal  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mul_st ^ div_st) begin
                    accept = 1'b1;
                    if (mul_st) begin
                        state_nx = MUL_STEP;
                    end else if (op_b == '0) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = DIV_STEP;
                    end
                end else if (mul_st & div_st) begin
                    illegal = 1'b1;
                end
            end
            MUL_STEP: begin
                busy = 1'b1;
                if (last) state_nx = FIN;
            end
            DIV_STEP: begin
                busy = 1'b1;
                if (last) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One iteration of whichever operation is in flight.
    always_comb begin
        sum   = lo[0] ? ({1'b0, hi[WIDTH-1:0]} + {1'b0, opnd}) : hi;
        shl   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        hi_nx = hi;
        lo_nx = lo;
        if (state == MUL_STEP) begin
            hi_nx = {1'b0, sum[WIDTH:1]};
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end else if (state == DIV_STEP) begin
            if (shl >= {1'b0, opnd}) begin
                hi_nx = shl - {1'b0, opnd};
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = shl;
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Results are loaded on the edge entering FIN so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            err_q  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            err_q <= illegal | div_zero;
            if (accept) begin
                opnd <= mul_st ? op_a : op_b;
                lo   <= mul_st ? op_b : op_a;
                hi   <= '0;
                cnt  <= '0;
                if (div_zero) begin
                    res_hi <= op_a;
                    res_lo <= '1;
                end
            end else if (busy) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    res_hi <= hi_nx[WIDTH-1:0];
                    res_lo <= lo_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Directed bench for seq_mul_div_unit at WIDTH=4 and WIDTH=8.
module tb_seq_mul_div_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       mul4, div4, busy4, done4, err4;
    logic [3:0] a4, b4, hi4, lo4;
    logic       mul8, div8, busy8, done8, err8;
    logic [7:0] a8, b8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    seq_mul_div_unit #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .mul_st(mul4), .div_st(div4),
        .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .err(err4),
        .res_hi(hi4), .res_lo(lo4)
    );

    seq_mul_div_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .mul_st(mul8), .div_st(div8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .err(err8),
        .res_hi(hi8), .res_lo(lo8)
    );

    typedef struct {
        logic       mul;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       err;
        int         lat;
    } vec_t;

    vec_t tv[8];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic op4(input logic m, input logic d, input logic [3:0] a,
                       input logic [3:0] b, output int lat, output int bc,
                       output logic [3:0] rh, output logic [3:0] rl,
                       output logic re);
        @(negedge clk);
        mul4 = m; div4 = d; a4 = a; b4 = b;
        @(posedge clk); #1;
        mul4 = 0; div4 = 0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0; bc = 0;
        while (!done4 && lat < 20) begin
            if (busy4) bc++;
            @(posedge clk); #1;
            lat++;
        end
        rh = hi4; rl = lo4; re = err4;
        @(posedge clk); #1;
        chk("done_pulse4", done4, 0);
        chk("hold4", {hi4, lo4}, {rh, rl});
    endtask

    task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [7:0] rh,
                       output logic [7:0] rl);
        @(negedge clk);
        mul8 = m; div8 = !m; a8 = a; b8 = b;
        @(posedge clk); #1;
        mul8 = 0; div8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rh = hi8; rl = lo8;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, bc, k;
        logic [3:0] rh, rl;
        logic [7:0] rh8, rl8;
        logic re, seen;

        tv[0] = '{1'b1, 4'd13, 4'd11, 4'h8, 4'hF, 1'b0, 4};
        tv[1] = '{1'b1, 4'd15, 4'd15, 4'hE, 4'h1, 1'b0, 4};
        tv[2] = '{1'b1, 4'd0,  4'd9,  4'h0, 4'h0, 1'b0, 4};
        tv[3] = '{1'b1, 4'd1,  4'd15, 4'h0, 4'hF, 1'b0, 4};
        tv[4] = '{1'b0, 4'd13, 4'd3,  4'h1, 4'h4, 1'b0, 4};
        tv[5] = '{1'b0, 4'd2,  4'd7,  4'h2, 4'h0, 1'b0, 4};
        tv[6] = '{1'b0, 4'd15, 4'd1,  4'h0, 4'hF, 1'b0, 4};
        tv[7] = '{1'b0, 4'd9,  4'd0,  4'h9, 4'hF, 1'b1, 0};

        rst_n = 0;
        mul4 = 0; div4 = 0; a4 = 0; b4 = 0;
        mul8 = 0; div8 = 0; a8 = 0; b8 = 0;
        #12;
        chk("rst_out4", {busy4, done4, err4, hi4, lo4}, 0);
        chk("rst_out8", {busy8, done8, err8, hi8, lo8}, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            op4(tv[i].mul, !tv[i].mul, tv[i].a, tv[i].b, lat, bc, rh, rl, re);
            chk($sformatf("lat[%0d]", i), lat, tv[i].lat);
            chk($sformatf("busy[%0d]", i), bc, tv[i].lat);
            chk($sformatf("hi[%0d]", i), rh, tv[i].hi);
            chk($sformatf("lo[%0d]", i), rl, tv[i].lo);
            chk($sformatf("err[%0d]", i), re, tv[i].err);
        end

        // Illegal command: both starts; results from 9/0 must be kept.
        @(negedge clk);
        mul4 = 1; div4 = 1;
        @(posedge clk); #1;
        mul4 = 0; div4 = 0;
        chk("ill_err", err4, 1);
        chk("ill_done", done4, 0);
        chk("ill_busy", busy4, 0);
        chk("ill_res", {hi4, lo4}, 8'h9F);
        @(posedge clk); #1;
        chk("ill_err_drop", err4, 0);

        // Start during busy is ignored.
        @(negedge clk);
        mul4 = 1; a4 = 4'd13; b4 = 4'd11;
        @(posedge clk); #1;
        mul4 = 0;
        @(negedge clk);
        div4 = 1; a4 = 4'd2; b4 = 4'd7;
        k = 0;
        while (!done4 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        div4 = 0;
        chk("busy_ign_lat", k, 4);
        chk("busy_ign_res", {hi4, lo4}, 8'h8F);
        @(posedge clk); #1;
        chk("busy_ign_idle", busy4, 0);

        // Async reset two steps into a multiply.
        @(negedge clk);
        mul4 = 1; a4 = 4'd13; b4 = 4'd11;
        @(posedge clk); #1;
        mul4 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("arst_out", {busy4, done4, err4, hi4, lo4}, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done4 || busy4) seen = 1;
        end
        chk("arst_quiet", seen, 0);
        op4(1, 0, 4'd7, 4'd6, lat, bc, rh, rl, re);
        chk("arst_fresh", {rh, rl}, 8'h2A);
        chk("arst_lat", lat, 4);

        op8(1, 8'd200, 8'd250, lat, rh8, rl8);
        chk("w8_mul", {rh8, rl8}, 16'hC350);
        chk("w8_mul_lat", lat, 8);
        op8(0, 8'd255, 8'd16, lat, rh8, rl8);
        chk("w8_div_q", rl8, 8'd15);
        chk("w8_div_r", rh8, 8'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
